interval_seconds_meter: RTL
===========================

// Module: interval_seconds_meter
// PURPOSE
//  Receiving end of the one-second timing scheme: measures the time between a start
//  pulse and a stop pulse in whole seconds. An internal prescaler counts TICKS_PER_SEC
//  clocks per second; completed seconds accumulate into a counter.
//  Result is latched with a 1-cycle done pulse. Sits beside the one-second timer in the
//  lab top level, timing user/stimulus events on the same 50 MHz clock.
// PARAMETERS
//  TICKS_PER_SEC  50000000  clocks per second; sims use 24; legal range >= 2
//  PRE_W          26        prescaler width; must satisfy 2^PRE_W > TICKS_PER_SEC-1
//  SEC_W          8         width of the seconds counter and the result
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      reset, asynchronous, active-low (0 = reset)
//  start     in   1      1-cycle pulse: begin a measurement
//  stop      in   1      1-cycle pulse: end a measurement
//  busy      out  1      1 while in RUN
//  done      out  1      1-cycle pulse: seconds/overflow hold a new result
//  seconds   out  SEC_W  latched whole seconds of the last measurement
//  overflow  out  1      latched: last measurement hit the 2^SEC_W-1 ceiling
// BEHAVIOUR
//  - Reset (rst=0, any time, incl. mid-measurement): state=IDLE, prescaler=0, sec_cnt=0,
//    busy=0, done=0, seconds=0, overflow=0. No done is emitted for an aborted run.
//  - FSM states: IDLE, RUN. All outputs registered.
//  - IDLE: start=1 -> RUN next cycle; prescaler<=0, sec_cnt<=0, ovf_int<=0. stop ignored.
//    Simultaneous start&stop in IDLE: start wins, stop dropped.
//  - RUN: prescaler counts 0..TICKS_PER_SEC-1. At TICKS_PER_SEC-1 it wraps to 0, and
//    sec_cnt increments that same edge.
//  - Saturation: sec_cnt at 2^SEC_W-1 does not wrap; on a further wrap sec_cnt holds and
//    ovf_int<=1 (sticky until next start).
//  - RUN, stop=1 (start also 1 or not): on that edge seconds<=sec_cnt (pre-increment
//    value if a wrap coincides). Same edge: overflow<=ovf_int, done<=1, state<=IDLE.
//  - done: high exactly one cycle, the cycle after stop is sampled (latency 1).
//  - RUN, start=1 with stop=0: restart, i.e. prescaler, sec_cnt and ovf_int cleared.
//    seconds/overflow untouched; no done.
//  - seconds/overflow hold their values until the next completed measurement.
//  - Partial seconds are truncated (floor); stop before first wrap -> seconds=0.
//  - busy=1 from the cycle after start through the cycle stop is sampled.
// CONFIGURATION
//  INTERVAL_METER_AUTOSTOP_EN defined: on the edge ovf_int would first set, the meter
//    ends by itself. It latches seconds=2^SEC_W-1 and overflow=1, pulses done, goes IDLE.
//  Not defined: meter saturates, stays in RUN until stop, overflow reported at stop.
// TESTING (TICKS_PER_SEC=24, SEC_W=4, 20 ns clock)
//  1 rst=0 for 3 cycles, release; no start for 5 cycles.
//    -> busy=0, done=0, seconds=0, overflow=0 throughout.
//  2 start pulse, stop pulse 50 cycles after start sampled.
//    -> 1 done pulse next cycle, seconds=2, overflow=0, busy=0 after.
//  3 start, stop 10 cycles later.
//    -> done, seconds=0; earlier result 2 replaced; outputs hold 30 idle cycles.
//  4 start, restart-start at cycle 30, stop 30 cycles after restart.
//    -> single done, seconds=1.
//  5 start, no stop for 24*17 cycles.
//    -> without macro: stop -> seconds=15, overflow=1.
//    -> with macro: done at 16th wrap, seconds=15, overflow=1, busy=0.
//  6 start, drive rst=0 at cycle 40, release.
//    -> no done, all outputs 0; start&stop same cycle in IDLE -> RUN, no done.

Source files
------------

// File: rtl/interval_seconds_meter.sv
// -----------------------------------------------------------------------------
// interval_seconds_meter
//
// Measures the time between a start pulse and a stop pulse in whole seconds.
// A prescaler counts TICKS_PER_SEC clocks per second. Each completed second
// increments a saturating seconds counter. The result is latched on stop and
// announced with a one-cycle done pulse.
//
// Parameters
//   TICKS_PER_SEC  clocks per second (>= 2)
//   PRE_W          prescaler width, 2^PRE_W > TICKS_PER_SEC-1
//   SEC_W          width of the seconds counter and result
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low (0 = reset)
//   start     in   1-cycle pulse: begin (or restart) a measurement
//   stop      in   1-cycle pulse: end a measurement
//   busy      out  1 while a measurement is running
//   done      out  1-cycle pulse: seconds/overflow hold a new result
//   seconds   out  latched whole seconds of the last measurement
//   overflow  out  latched: last measurement hit the 2^SEC_W-1 ceiling
//
// Build option
//   INTERVAL_METER_AUTOSTOP_EN  when defined, the meter ends a measurement by
//   itself on the second that would first overflow the counter (latching
//   seconds=2^SEC_W-1, overflow=1, pulsing done). When undefined the counter
//   saturates and the meter waits for stop.
// -----------------------------------------------------------------------------
module interval_seconds_meter #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRE_W         = 26,
  parameter int unsigned SEC_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [SEC_W-1:0] seconds,
  output logic             overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX  = '1;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic               ovf_q, ovf_d;
  logic [SEC_W-1:0]   seconds_d;
  logic               overflow_d;
  logic               done_d;
  logic               wrap;

  // Last tick of the current second.
  assign wrap = (pre_q == PRE_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    sec_d      = sec_q;
    ovf_d      = ovf_q;
    seconds_d  = seconds;
    overflow_d = overflow;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A stop arriving with (or without) start is meaningless here.
        if (start) begin
          state_d = RUN;
          pre_d   = '0;
          sec_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      RUN: begin
        if (stop) begin
          // Latch the count as it stands before this edge; a coinciding
          // wrap is deliberately not included.
          seconds_d  = sec_q;
          overflow_d = ovf_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else if (start) begin
          // Restart: the previous result stays visible.
          pre_d = '0;
          sec_d = '0;
          ovf_d = 1'b0;
        end else if (wrap) begin
          pre_d = '0;
          if (sec_q != SEC_MAX) begin
            sec_d = sec_q + 1'b1;
          end else if (!ovf_q) begin
            // Counter saturated; this is the first second it cannot hold.
            ovf_d = 1'b1;
`ifdef INTERVAL_METER_AUTOSTOP_EN
            seconds_d  = SEC_MAX;
            overflow_d = 1'b1;
            done_d     = 1'b1;
            state_d    = IDLE;
`endif
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      sec_q    <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seconds  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      sec_q    <= sec_d;
      ovf_q    <= ovf_d;
      busy     <= (state_d == RUN);
      done     <= done_d;
      seconds  <= seconds_d;
      overflow <= overflow_d;
    end
  end

endmodule
